// File: rtl/entity_line_renderer.sv
// Renders one display line: clears a line buffer, then paints every 48x48 entity
// that crosses the requested line, walking the entity list in index order.
module entity_line_renderer #(
  parameter int         LINE_WIDTH    = 480,
  parameter int         ENT_SIZE      = 48,
  parameter logic [2:0] OUTLINE_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  input  logic [7:0]  entities_number,
  output logic [7:0]  address_read_ent,
  input  logic [20:0] data_read_ent,
  output logic [8:0]  lb_address,
  output logic [2:0]  lb_data,
  output logic        lb_wren,
  output logic        busy,
  output logic        line_done
);

  localparam logic [9:0] LW = 10'(LINE_WIDTH);
  localparam logic [9:0] ES = 10'(ENT_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_CHECK, S_PAINT, S_NEXT, S_DONE
  } state_t;

  state_t     r_state, w_state_next;
  logic [9:0] r_cnt, w_cnt_next;
  logic [7:0] r_idx, w_idx_next;
  logic [8:0] r_y, w_y_next;
  logic [7:0] r_n, w_n_next;
  logic [8:0] r_ex, w_ex_next;
  logic [9:0] r_dy, w_dy_next;
  logic [2:0] r_sprite, w_sprite_next;
  logic [7:0] r_addr, w_addr_next;
  logic [8:0] r_lb_addr, w_lb_addr_next;
  logic [2:0] r_lb_data, w_lb_data_next;
  logic       r_lb_wren, w_lb_wren_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;

  logic [9:0] w_dy_calc;
  logic [9:0] w_paint_addr;
  logic [7:0] w_idx_inc;
  logic       w_hit;
  logic       w_edge_pix;

  // Bit 9 of the 10-bit difference is the borrow: the entity starts below this line.
  assign w_dy_calc    = {1'b0, r_y} - {1'b0, data_read_ent[17:9]};
  assign w_hit        = !w_dy_calc[9] && (w_dy_calc < ES) &&
                        ({1'b0, data_read_ent[8:0]} < LW);
  assign w_paint_addr = {1'b0, r_ex} + r_cnt;
  assign w_edge_pix   = (r_dy == 10'd0) || (r_dy == ES - 10'd1) ||
                        (r_cnt == 10'd0) || (r_cnt == ES - 10'd1);
  assign w_idx_inc    = r_idx + 8'd1;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_idx_next     = r_idx;
    w_y_next       = r_y;
    w_n_next       = r_n;
    w_ex_next      = r_ex;
    w_dy_next      = r_dy;
    w_sprite_next  = r_sprite;
    w_addr_next    = r_addr;
    w_lb_addr_next = r_lb_addr;
    w_lb_data_next = r_lb_data;
    w_lb_wren_next = 1'b0;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (line_start) begin
          w_y_next     = line_y;
          w_n_next     = entities_number;
          w_busy_next  = 1'b1;
          w_cnt_next   = 10'd0;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_lb_wren_next = 1'b1;
        w_lb_addr_next = r_cnt[8:0];
        w_lb_data_next = BG_COLOR;
        if (r_cnt == LW - 10'd1) begin
          w_cnt_next   = 10'd0;
          w_idx_next   = 8'd0;
          w_addr_next  = 8'd0;
          w_state_next = (r_n == 8'd0) ? S_DONE : S_FETCH;
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end
      S_FETCH: w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_CHECK;
      S_CHECK: begin
        w_ex_next     = data_read_ent[8:0];
        w_dy_next     = w_dy_calc;
        w_sprite_next = data_read_ent[20:18];
        w_cnt_next    = 10'd0;
        w_state_next  = w_hit ? S_PAINT : S_NEXT;
      end
      S_PAINT: begin
        // Off-screen pixels still take their cycle so PAINT length is fixed.
        w_lb_wren_next = (w_paint_addr < LW);
        w_lb_addr_next = w_paint_addr[8:0];
        w_lb_data_next = w_edge_pix ? OUTLINE_COLOR : r_sprite;
        if (r_cnt == ES - 10'd1) begin
          w_cnt_next   = 10'd0;
          w_state_next = S_NEXT;
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end
      S_NEXT: begin
        if (w_idx_inc == r_n) begin
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = w_idx_inc;
          w_addr_next  = w_idx_inc;
          w_state_next = S_FETCH;
        end
      end
      S_DONE: begin
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_y       <= '0;
      r_n       <= '0;
      r_ex      <= '0;
      r_dy      <= '0;
      r_sprite  <= '0;
      r_addr    <= '0;
      r_lb_addr <= '0;
      r_lb_data <= '0;
      r_lb_wren <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_y       <= w_y_next;
      r_n       <= w_n_next;
      r_ex      <= w_ex_next;
      r_dy      <= w_dy_next;
      r_sprite  <= w_sprite_next;
      r_addr    <= w_addr_next;
      r_lb_addr <= w_lb_addr_next;
      r_lb_data <= w_lb_data_next;
      r_lb_wren <= w_lb_wren_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
    end
  end

  assign address_read_ent = r_addr;
  assign lb_address       = r_lb_addr;
  assign lb_data          = r_lb_data;
  assign lb_wren          = r_lb_wren;
  assign busy             = r_busy;
  assign line_done        = r_done;

endmodule

// File: tb/tb_entity_line_renderer.sv
// Bench for entity_line_renderer: a synchronous entity RAM, a line-buffer capture
// monitor, and a pixel-level reference model of how a line should end up.
module tb_entity_line_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic [7:0]  entities_number = '0;
  logic [7:0]  address_read_ent;
  logic [20:0] data_read_ent;
  logic [8:0]  lb_address;
  logic [2:0]  lb_data;
  logic        lb_wren, busy, line_done;

  logic [20:0] ent_mem [0:255];
  logic [2:0]  obs_buf [0:479];
  int          exp_buf [0:479];
  int          exp_wr;
  int          n_vec = 0;
  int          n_miss = 0;
  int          wr_cnt, done_cnt, bad_addr;
  logic        mon_clr = 1'b0;

  entity_line_renderer dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .entities_number(entities_number), .address_read_ent(address_read_ent),
    .data_read_ent(data_read_ent), .lb_address(lb_address), .lb_data(lb_data),
    .lb_wren(lb_wren), .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_read_ent <= ent_mem[address_read_ent];

  // Capture line-buffer writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      wr_cnt = 0; done_cnt = 0; bad_addr = 0;
      for (int a = 0; a < 480; a++) obs_buf[a] = 3'bx;
    end else begin
      if (lb_wren) begin
        wr_cnt++;
        if (lb_address < 9'd480) obs_buf[lb_address] = lb_data;
        else bad_addr++;
      end
      if (line_done) done_cnt++;
    end
  end

  // Reference: paint entities in order, clip at the right edge, outline on borders.
  function automatic int model_line(input int y, input int n);
    int lat = 482;
    exp_wr = 480;
    for (int a = 0; a < 480; a++) exp_buf[a] = 0;
    for (int i = 0; i < n; i++) begin
      int ex = int'(ent_mem[i][8:0]);
      int ey = int'(ent_mem[i][17:9]);
      int sp = int'(ent_mem[i][20:18]);
      lat += 4;
      if (y >= ey && (y - ey) < 48 && ex < 480) begin
        int dy = y - ey;
        lat += 48;
        for (int k = 0; k < 48; k++) begin
          if (ex + k < 480) begin
            exp_wr++;
            exp_buf[ex + k] = (dy == 0 || dy == 47 || k == 0 || k == 47) ? 7 : sp;
          end
        end
      end
    end
    return lat;
  endfunction

  function automatic int buf_diff();
    int d = 0;
    for (int a = 0; a < 480; a++)
      if (obs_buf[a] !== 3'(exp_buf[a])) d++;
    return d;
  endfunction

  task automatic start_line(input int y, input int n);
    mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1;
    line_y = 9'(y); entities_number = 8'(n); line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
  endtask

  task automatic run_line(input int y, input int n, output int lat);
    start_line(y, n);
    lat = 1;
    while (line_done !== 1'b1 && lat < 5000) begin
      @(posedge clk); #1 lat++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_vec++;
    if ({address_read_ent, lb_address, lb_data, lb_wren, busy, line_done} !== 23'd0) begin
      n_miss++;
      $display("FAIL reset_outputs got addr=%h lba=%h lbd=%h wren=%b busy=%b done=%b exp all 0",
               address_read_ent, lb_address, lb_data, lb_wren, busy, line_done);
    end
    repeat (5) @(posedge clk);
    #1 line_y = 9'd3; entities_number = 8'd0; line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++; $display("FAIL reset_accept_busy got=%b exp=1", busy);
    end
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_empty();
    int lat, elat;
    elat = model_line(10, 0);
    run_line(10, 0, lat);
    n_vec++; if (lat !== elat) begin n_miss++; $display("FAIL empty_latency got=%0d exp=%0d", lat, elat); end
    n_vec++; if (wr_cnt !== 480) begin n_miss++; $display("FAIL empty_writes got=%0d exp=480", wr_cnt); end
    n_vec++; if (buf_diff() !== 0) begin n_miss++; $display("FAIL empty_buffer got=%0d bad pixels exp=0", buf_diff()); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL empty_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_single_hit();
    int ys [4] = '{48, 60, 96, 47};
    int lat, elat;
    ent_mem[0] = {3'b100, 9'd48, 9'd96};
    foreach (ys[t]) begin
      elat = model_line(ys[t], 1);
      run_line(ys[t], 1, lat);
      n_vec++; if (lat !== elat) begin n_miss++; $display("FAIL single_y%0d_latency got=%0d exp=%0d", ys[t], lat, elat); end
      n_vec++; if (wr_cnt !== exp_wr) begin n_miss++; $display("FAIL single_y%0d_writes got=%0d exp=%0d", ys[t], wr_cnt, exp_wr); end
      n_vec++; if (buf_diff() !== 0) begin n_miss++; $display("FAIL single_y%0d_buffer got=%0d bad pixels exp=0", ys[t], buf_diff()); end
      if (ys[t] == 60) begin
        n_vec++;
        if (obs_buf[96] !== 3'd7 || obs_buf[97] !== 3'd4 || obs_buf[142] !== 3'd4 || obs_buf[143] !== 3'd7) begin
          n_miss++;
          $display("FAIL single_y60_pixels got=%0d,%0d,%0d,%0d exp=7,4,4,7",
                   obs_buf[96], obs_buf[97], obs_buf[142], obs_buf[143]);
        end
      end
    end
  endtask

  task automatic test_clip();
    int lat;
    ent_mem[0] = {3'b011, 9'd0, 9'd456};
    run_line(5, 1, lat);
    n_vec++; if (lat !== 534) begin n_miss++; $display("FAIL clip_latency got=%0d exp=534", lat); end
    n_vec++; if (wr_cnt !== 504) begin n_miss++; $display("FAIL clip_writes got=%0d exp=504", wr_cnt); end
    n_vec++; if (bad_addr !== 0) begin n_miss++; $display("FAIL clip_offscreen got=%0d exp=0", bad_addr); end
    n_vec++;
    if (obs_buf[456] !== 3'd7 || obs_buf[457] !== 3'd3 || obs_buf[479] !== 3'd3 || obs_buf[455] !== 3'd0) begin
      n_miss++;
      $display("FAIL clip_pixels got=%0d,%0d,%0d,%0d exp=7,3,3,0",
               obs_buf[456], obs_buf[457], obs_buf[479], obs_buf[455]);
    end
  endtask

  task automatic test_overlap();
    int lat, elat;
    ent_mem[0] = {3'b000, 9'd0, 9'd0};
    ent_mem[1] = {3'b010, 9'd0, 9'd20};
    elat = model_line(10, 2);
    run_line(10, 2, lat);
    n_vec++; if (lat !== elat) begin n_miss++; $display("FAIL overlap_latency got=%0d exp=%0d", lat, elat); end
    n_vec++; if (buf_diff() !== 0) begin n_miss++; $display("FAIL overlap_buffer got=%0d bad pixels exp=0", buf_diff()); end
    n_vec++;
    if (obs_buf[19] !== 3'd0 || obs_buf[20] !== 3'd7 || obs_buf[47] !== 3'd2 || obs_buf[66] !== 3'd2) begin
      n_miss++;
      $display("FAIL overlap_pixels got=%0d,%0d,%0d,%0d exp=0,7,2,2",
               obs_buf[19], obs_buf[20], obs_buf[47], obs_buf[66]);
    end
  endtask

  task automatic test_random();
    int lat, elat, y, n, t;
    for (int r = 0; r < 6; r++) begin
      y = int'($urandom_range(0, 479));
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        t = y - int'($urandom_range(0, 55));
        if (t < 0 || $urandom_range(0, 3) == 0) t = int'($urandom_range(0, 511));
        ent_mem[i] = {3'($urandom_range(0, 7)), 9'(t), 9'($urandom_range(0, 511))};
      end
      elat = model_line(y, n);
      run_line(y, n, lat);
      n_vec++; if (lat !== elat) begin n_miss++; $display("FAIL random%0d_latency got=%0d exp=%0d", r, lat, elat); end
      n_vec++; if (wr_cnt !== exp_wr) begin n_miss++; $display("FAIL random%0d_writes got=%0d exp=%0d", r, wr_cnt, exp_wr); end
      n_vec++; if (buf_diff() !== 0) begin n_miss++; $display("FAIL random%0d_buffer got=%0d bad pixels exp=0", r, buf_diff()); end
      n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL random%0d_done got=%0d exp=1", r, done_cnt); end
    end
  endtask

  task automatic test_busy_start();
    int lat, elat;
    ent_mem[0] = {3'b010, 9'd100, 9'd200};
    elat = model_line(100, 1);
    start_line(100, 1);
    lat = 1;
    repeat (50) begin @(posedge clk); #1 lat++; end
    line_y = 9'd300; entities_number = 8'd5; line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0; lat++;
    while (line_done !== 1'b1 && lat < 5000) begin @(posedge clk); #1 lat++; end
    repeat (700) @(negedge clk);
    n_vec++; if (lat !== elat) begin n_miss++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, elat); end
    n_vec++; if (done_cnt !== 1) begin n_miss++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt); end
    n_vec++; if (buf_diff() !== 0) begin n_miss++; $display("FAIL busy_start_buffer got=%0d bad pixels exp=0", buf_diff()); end
  endtask

  task automatic test_reset_paint();
    ent_mem[0] = {3'b001, 9'd0, 9'd0};
    start_line(10, 1);
    repeat (489) @(posedge clk);
    #1;
    n_vec++;
    if (lb_wren !== 1'b1 || lb_address !== 9'd5) begin
      n_miss++; $display("FAIL rst_paint_precondition got wren=%b addr=%0d exp wren=1 addr=5", lb_wren, lb_address);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_vec++;
    if (lb_wren !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0) begin
      n_miss++; $display("FAIL rst_paint_outputs got wren=%b busy=%b done=%b exp 0,0,0", lb_wren, busy, line_done);
    end
    repeat (200) @(negedge clk);
    n_vec++; if (done_cnt !== 0) begin n_miss++; $display("FAIL rst_paint_done got=%0d exp=0", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ent_mem[i] = 21'd0;
    test_reset();
    test_empty();
    test_single_hit();
    test_clip();
    test_overlap();
    test_random();
    test_busy_start();
    test_reset_paint();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/entity_line_renderer.md
# entity_line_renderer

Downstream consumer of the entity list produced by the entities drawer. For each display line it clears a one-line pixel buffer, walks the entity list in index order, and paints every 48×48 entity that intersects the requested line. Later entries overwrite earlier ones, so backgrounds are written first and moving objects land on top. The scan-out stage reads the finished line buffer while the renderer prepares the next line.

## Interface
- `LINE_WIDTH`, 480: visible pixels per line; line-buffer addresses are 0..LINE_WIDTH-1.
- `ENT_SIZE`, 48: entity edge in pixels.
- `OUTLINE_COLOR`, 3'b111: pixel value for an entity's border pixels.
- `BG_COLOR`, 3'b000: value written during clear.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `line_start` in 1: single-cycle request to render line `line_y`.
- `line_y` in 9: line to render; sampled with `line_start`.
- `entities_number` in 8: number of valid entries; sampled with `line_start`.
- `address_read_ent` out 8: entity memory read address.
- `data_read_ent` in 21: entity entry {sprite[20:18], y[17:9], x[8:0]}, valid one cycle after its address.
- `lb_address` out 9: line-buffer write address.
- `lb_data` out 3: line-buffer write data.
- `lb_wren` out 1: line-buffer write enable.
- `busy` out 1: high from acceptance until `line_done`.
- `line_done` out 1: single-cycle pulse when the line is complete.

## Operation
- **Reset values:** all outputs are 0, the state is IDLE, and the counters are 0.
- **IDLE:**
  - `line_start` latches `line_y` into Y and `entities_number` into N, sets `busy`, and moves to CLEAR.
  - `line_start` is ignored in every other state. No queueing.
- **CLEAR:** writes `BG_COLOR` to addresses 0..LINE_WIDTH-1, one per cycle, then moves to FETCH with entity index i=0.
  - If N=0, it moves straight to DONE instead.
- **FETCH:** drives `address_read_ent`=i, then moves to WAIT.
- **WAIT:** one cycle of RAM latency, then moves to CHECK.
- **CHECK:** registers the entry. With dy = Y − ey computed in 10 bits, the entity hits when:
  - there is no borrow, and
  - dy < ENT_SIZE, and
  - ex < LINE_WIDTH.
  - On a hit, go to PAINT with k=0. On a miss, go to NEXT.
- **PAINT:** writes one pixel per cycle for k = 0..ENT_SIZE-1.
  - Address is ex+k, computed 10 bits wide.
  - Write is suppressed (`lb_wren`=0) when ex+k ≥ LINE_WIDTH, but k still advances. PAINT always lasts exactly ENT_SIZE cycles.
  - Data is `OUTLINE_COLOR` if dy∈{0, ENT_SIZE-1} or k∈{0, ENT_SIZE-1}; otherwise the sprite code.
- **NEXT:** i+1; if i+1 = N go to DONE, else go to FETCH.
- **DONE:** pulses `line_done` for one cycle, drops `busy`, and returns to IDLE.
- **Sprite codes:** all sprite codes, including 000, are painted. There is no transparency.
- **Reset mid-operation:** on the next edge the block is in IDLE, `lb_wren`=0, `busy`=0, and no `line_done` is issued. A partially rendered buffer is left as is.

## Timing
- The first clear write happens on the cycle after `line_start` is sampled.
- Per-line latency from `line_start` to `line_done`: LINE_WIDTH + Σ(4 per entity) + ENT_SIZE × hits + 2 cycles.
  - Example: N=1 with one hit gives 480 + 4 + 48 + 2 = 534.
- `address_read_ent` is held stable from FETCH through CHECK.
- `lb_address`, `lb_data` and `lb_wren` are registered and change together.
- `lb_wren` is high only in CLEAR and in unsuppressed PAINT cycles.
- Entity memory contents must not change while `busy` is high. Swapping memory is the producer's responsibility.

## Test plan
- **Reset:** assert `reset` for 2 cycles → all outputs 0. `line_start` 5 cycles later is accepted and `busy` goes to 1 the next cycle.
- **Empty list:** N=0, `line_y`=10 → exactly 480 writes of 0 to addresses 0..479, then `line_done` 482 cycles after the start edge, with no entity read issued.
- **Single hit:** entry {3'b100, y=48, x=96}.
  - `line_y`=48 → addresses 96..143 all 3'b111.
  - `line_y`=60 → address 96 = 7, addresses 97..142 = 4, address 143 = 7.
  - `line_y`=96 and `line_y`=47 → no PAINT.
- **Clip:** entry {3'b011, y=0, x=456}, `line_y`=5 → writes only at 456..479, but PAINT still lasts 48 cycles.
- **Overlap:** entry 0 {000, 0, 0} and entry 1 {010, 0, 20}, `line_y`=10 → final buffer has 1..19 = 0, 20 = 7, 21..66 = 2.
- **Busy and reset:**
  - A `line_start` pulsed during CLEAR is ignored, giving exactly one `line_done`.
  - A `reset` pulse during PAINT gives `lb_wren`=0 and `busy`=0 the next cycle and no `line_done`.
